rf_stream_reader: RTL and testbench
===================================

RF_STREAM_READER -- requirements
Module: rf_stream_reader

Interface
REQ-001 SHALL have parameter AW, default 10, meaning RF address width.
REQ-002 SHALL have parameter DW, default 8, meaning RF data width.
REQ-003 SHALL run on one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  single clock; all state on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  command strobe, sampled only in IDLE.
REQ-007 base_addr  input  AW  first RF address of the burst.
REQ-008 length  input  AW+1  word count, 0..2^AW.
REQ-009 busy  output  1  high from the cycle after start is accepted until done.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 rf_rd_addr  output  AW  to the RF read-address port.
REQ-012 rf_rd_me_en  output  1  RF read enable; the RF registers rf_rd_addr on this.
REQ-013 rf_rd_data  input  DW  RF data, valid the cycle after an enabled address edge and held while rf_rd_me_en is low.
REQ-014 out_data  output  DW  stream data.
REQ-015 out_valid  output  1  stream valid.
REQ-016 out_ready  input  1  stream ready.

Function
REQ-017 FSM states SHALL be IDLE, RUN and FLUSH, with reset state IDLE.
REQ-018 IDLE->RUN SHALL occur on start with length!=0; IDLE->FLUSH SHALL occur on start with length==0; start SHALL be ignored in RUN and FLUSH.
REQ-019 On acceptance, the block SHALL latch rd_ptr=base_addr, issue_cnt=length and beat_cnt=length.
REQ-020 In RUN, rf_rd_me_en SHALL be 1 iff issue_cnt!=0 and (words in flight + words buffered) < 2; each issue SHALL set rf_rd_addr=rd_ptr, then increment rd_ptr and decrement issue_cnt.
REQ-021 rd_ptr SHALL wrap modulo 2^AW (e.g. 0x3FF -> 0x000) with no error indication.
REQ-022 Read latency SHALL be: start sampled at edge T0 -> rf_rd_me_en high in cycle T0..T1 -> RF captures at T1 -> data written into the output buffer at T2 -> out_valid high after T2.
REQ-023 The output buffer SHALL be a 2-entry FIFO that sustains 1 word/cycle with out_ready held high after the initial 2-cycle latency.
REQ-024 A beat SHALL occur when out_valid&&out_ready; each beat SHALL decrement beat_cnt.
REQ-025 While out_valid&&!out_ready, out_data SHALL hold stable and out_valid SHALL stay high.
REQ-026 Words SHALL be emitted in address order, with no duplicates and no drops under any out_ready pattern.
REQ-027 The buffer SHALL never overflow; by REQ-020 credit, an issue SHALL never be made into a full pipeline.
REQ-028 RUN->FLUSH SHALL occur on the beat that makes beat_cnt 0; FLUSH SHALL pulse done for one cycle and return to IDLE.
REQ-029 busy SHALL be high in RUN and FLUSH.
REQ-030 A length==0 command SHALL give done one cycle after start, with no RF read and no beat.
REQ-031 length==2^AW SHALL read every address exactly once, wrapping from base_addr.
REQ-032 start coincident with the final beat SHALL be ignored; a new command SHALL be accepted the cycle after done.
REQ-033 rf_rd_addr SHALL hold its last value when rf_rd_me_en is low.

Reset
REQ-034 rst SHALL force, at the next edge: state=IDLE, busy=0, done=0, out_valid=0, rf_rd_me_en=0, rf_rd_addr=0, out_data=0, all counters 0, buffer empty.
REQ-035 rst asserted mid-burst SHALL discard in-flight and buffered words, and no done SHALL be generated.
REQ-036 rst SHALL take priority over start.

Structure
REQ-037 Shared package rf_stream_pkg SHALL hold the state encoding constants (IDLE/RUN/FLUSH) and the buffer depth constant (2).
REQ-038 The 2-entry output buffer SHALL be the sub-module rf_stream_skid, parameterised by DW.
REQ-039 The block SHALL be paired in benches with generic_2p_rf at matching AW and DW.

Verification
REQ-040 Scenario: preload RF[i]=i; base=0x010, length=4, out_ready=1 -> out_data 0x10,0x11,0x12,0x13 on consecutive cycles, first out_valid 2 cycles after start, done 1 cycle after the last beat.
REQ-041 Scenario: base=0x3FE, length=4 -> rf_rd_addr sequence 0x3FE,0x3FF,0x000,0x001, and data in the same order.
REQ-042 Scenario: length=8 with out_ready toggling 1,0,0,1,0,1... -> all 8 words in order, out_data stable while stalled, at most 2 outstanding reads.
REQ-043 Scenario: length=0 -> done 1 cycle after start, rf_rd_me_en never high, out_valid never high.
REQ-044 Scenario: rst asserted after 3 beats of length=10 -> next cycle out_valid=0, busy=0, no done; a new start base=0, length=2 then returns RF[0],RF[1].
REQ-045 Scenario: start pulsed every cycle during a burst of length=5 -> exactly 5 beats and 1 done; the extra starts are ignored.

Source files
------------

// File: rtl/rf_stream_pkg.sv
// Shared constants for the RF stream reader.
//   - FSM state encodings (IDLE / RUN / FLUSH), 2 bits wide.
//   - Output buffer depth and the width of its occupancy counter.
package rf_stream_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  localparam int unsigned BufDepth = 2;
  localparam int unsigned BufCntW  = 2;  // holds 0..BufDepth

endpackage

// File: rtl/rf_stream_reader_if.sv
// Bundle of the reader's command, RF read-port and output-stream signals.
//   master : the reader (consumes commands and RF data, drives the stream)
//   slave  : the environment (issues commands, owns the RF, sinks the stream)
interface rf_stream_reader_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 8
);

  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] rf_rd_addr;
  logic          rf_rd_me_en;
  logic [DW-1:0] rf_rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    input  start, base_addr, length, rf_rd_data, out_ready,
    output busy, done, rf_rd_addr, rf_rd_me_en, out_data, out_valid
  );

  modport slave (
    output start, base_addr, length, rf_rd_data, out_ready,
    input  busy, done, rf_rd_addr, rf_rd_me_en, out_data, out_valid
  );

endinterface

// File: rtl/generic_2p_rf.sv
// Two-port register file: one synchronous write port, one registered read port.
//   clk                      : clock
//   wr_en/wr_addr/wr_data    : write port
//   rd_me_en/rd_addr         : read request; address captured on the edge when rd_me_en
//   rd_data                  : read data, valid after the capturing edge, held otherwise
module generic_2p_rf #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_me_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_me_en) begin
      rd_data <= mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/rf_stream_skid.sv
// Two-entry output FIFO for the RF stream reader.
//   clk, rst            : clock, synchronous active-high reset
//   wr_valid, wr_data   : write side (no backpressure; caller never writes when full)
//   rd_valid, rd_ready  : read-side handshake
//   rd_data             : head entry, stable while rd_valid && !rd_ready
//   count               : current occupancy (0..2)
module rf_stream_skid import rf_stream_pkg::*; #(
  parameter int unsigned DW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  input  logic [DW-1:0]      wr_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [DW-1:0]      rd_data,
  output logic [BufCntW-1:0] count
);

  logic [DW-1:0]      mem_q [BufDepth];
  // Single-bit pointers: toggling covers both entries of the 2-deep store.
  logic               wr_idx_q;
  logic               rd_idx_q;
  logic [BufCntW-1:0] count_q;
  logic               push;
  logic               pop;

  assign rd_valid = (count_q != '0);
  assign rd_data  = mem_q[rd_idx_q];
  assign count    = count_q;
  assign pop      = rd_valid && rd_ready;
  assign push     = wr_valid && (count_q != BufCntW'(BufDepth));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BufDepth; i++) begin
        mem_q[i] <= '0;
      end
      wr_idx_q <= 1'b0;
      rd_idx_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_idx_q] <= wr_data;
        wr_idx_q        <= ~wr_idx_q;
      end
      if (pop) begin
        rd_idx_q <= ~rd_idx_q;
      end
      count_q <= count_q + BufCntW'(push) - BufCntW'(pop);
    end
  end

endmodule

// File: rtl/rf_stream_reader.sv
// Streams a burst of RF words out on a valid/ready interface.
//   clk, rst : clock, synchronous active-high reset (wins over start)
//   bus      : command (start/base_addr/length, busy/done), RF read port
//              (rf_rd_addr/rf_rd_me_en/rf_rd_data) and output stream
//              (out_data/out_valid/out_ready)
// A command reads length words from base_addr upward (wrapping modulo 2^AW).
// Reads are credited against a 2-entry output FIFO so it can never overflow.
module rf_stream_reader import rf_stream_pkg::*; #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 8
) (
  input logic               clk,
  input logic               rst,
  rf_stream_reader_if.master bus
);

  localparam logic [AW:0] CntOne = (AW+1)'(1);

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      last_addr_q, last_addr_d;
  logic [AW:0]        issue_cnt_q, issue_cnt_d;
  logic [AW:0]        beat_cnt_q, beat_cnt_d;
  logic               pend_q;  // a read was issued last cycle; its data is on rf_rd_data
  logic               rd_en;
  logic               beat;
  logic [BufCntW-1:0] buf_count;
  logic [2:0]         used;

  assign beat = bus.out_valid && bus.out_ready;

  // Credit counts the word leaving this cycle as already gone, so a read can
  // be issued into the slot it frees; this is what sustains one word per cycle.
  assign used  = 3'(pend_q) + 3'(buf_count) - 3'(beat);
  assign rd_en = (state_q == StRun) && (issue_cnt_q != '0) && (used < 3'(BufDepth));

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    last_addr_d = last_addr_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          rd_ptr_d    = bus.base_addr;
          issue_cnt_d = bus.length;
          beat_cnt_d  = bus.length;
          state_d     = (bus.length == '0) ? StFlush : StRun;
        end
      end
      StRun: begin
        if (rd_en) begin
          rd_ptr_d    = rd_ptr_q + 1'b1;
          issue_cnt_d = issue_cnt_q - CntOne;
          last_addr_d = rd_ptr_q;
        end
        if (beat) begin
          beat_cnt_d = beat_cnt_q - CntOne;
          if (beat_cnt_q == CntOne) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rd_ptr_q    <= '0;
      last_addr_q <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      last_addr_q <= last_addr_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      pend_q      <= rd_en;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StFlush);
  assign bus.rf_rd_me_en = rd_en;
  // Present the live pointer only while reading; otherwise hold the last issued address.
  assign bus.rf_rd_addr  = rd_en ? rd_ptr_q : last_addr_q;

  rf_stream_skid #(
    .DW(DW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (pend_q),
    .wr_data  (bus.rf_rd_data),
    .rd_valid (bus.out_valid),
    .rd_ready (bus.out_ready),
    .rd_data  (bus.out_data),
    .count    (buf_count)
  );

endmodule

// File: tb/tb_rf_stream_reader.sv
module tb_rf_stream_reader;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int RfWords = 1 << AW;

  logic          clk;
  logic          rst;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;

  rf_stream_reader_if #(.AW(AW), .DW(DW)) bus ();

  rf_stream_reader #(.AW(AW), .DW(DW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  generic_2p_rf #(.AW(AW), .DW(DW)) u_rf (
    .clk      (clk),
    .wr_en    (rf_wr_en),
    .wr_addr  (rf_wr_addr),
    .wr_data  (rf_wr_data),
    .rd_me_en (bus.rf_rd_me_en),
    .rd_addr  (bus.rf_rd_addr),
    .rd_data  (bus.rf_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboards: expected RF read addresses and expected stream words.
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];

  int issue_total = 0;
  int beat_total = 0;
  int done_total = 0;
  int last_beat_cyc = -1;
  int done_cyc = -1;
  int first_valid = -1;
  int inflight = 0;
  int max_out = 0;
  bit stalled_prev = 1'b0;
  logic [DW-1:0] held;

  // Monitor: samples on the falling edge, between active edges.
  always @(negedge clk) begin
    if (rst) begin
      inflight = 0;
      stalled_prev = 1'b0;
    end else begin
      if (inflight > max_out) max_out = inflight;
      if (bus.rf_rd_me_en) begin
        issue_total++;
        if (exp_addr.size() == 0) check("extra_rf_read", 1, 0);
        else check("rf_rd_addr", int'(bus.rf_rd_addr), int'(exp_addr.pop_front()));
      end
      if (stalled_prev) begin
        check("stall_valid", int'(bus.out_valid), 1);
        check("stall_data", int'(bus.out_data), int'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        beat_total++;
        last_beat_cyc = cyc;
        if (exp_data.size() == 0) check("extra_beat", 1, 0);
        else check("out_data", int'(bus.out_data), int'(exp_data.pop_front()));
      end
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (bus.done) begin
        done_total++;
        done_cyc = cyc;
      end
      inflight = inflight + int'(bus.rf_rd_me_en) - int'(bus.out_valid && bus.out_ready);
      stalled_prev = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
    end
  end

  // Ready driver: mode 0 holds ready high, mode 1 repeats 1,0,0,1,0,1.
  int ready_mode = 0;
  logic [5:0] ready_pat = 6'b101001;
  int ready_ph = 0;

  // RF is preloaded with RF[i] = i (truncated to DW).
  function automatic logic [DW-1:0] rf_model(input logic [AW-1:0] a);
    return a[DW-1:0];
  endfunction

  task automatic push_expected(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    for (int i = 0; i < len; i++) begin
      a = base + AW'(i);
      exp_addr.push_back(a);
      exp_data.push_back(rf_model(a));
    end
  endtask

  task automatic run_burst(input logic [AW-1:0] base, input int len, input bit spam);
    int st_cyc;
    int b0, d0, i0;
    bit got_done;
    push_expected(base, len);
    first_valid = -1;
    max_out = 0;
    b0 = beat_total;
    d0 = done_total;
    i0 = issue_total;
    got_done = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.base_addr = base;
    bus.length = (AW+1)'(len);
    st_cyc = cyc;
    @(posedge clk); #1;
    if (!spam) bus.start = 1'b0;
    for (int k = 0; k < 4 * len + 50; k++) begin
      if (bus.done) begin
        bus.start = 1'b0;  // must be low before the FSM is back in IDLE
        got_done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    if (!got_done) check("done_timeout", 0, 1);
    repeat (4) @(posedge clk);
    #1;
    check("beat_count", beat_total - b0, len);
    check("done_count", done_total - d0, 1);
    check("read_count", issue_total - i0, len);
    check("data_left", exp_data.size(), 0);
    check("addr_left", exp_addr.size(), 0);
    check("max_outstanding_le2", int'(max_out <= 2), 1);
    if (len == 0) begin
      // done in the cycle right after the one that drove start
      check("len0_done_latency", done_cyc - st_cyc, 1);
      check("len0_no_valid", first_valid, -1);
    end else begin
      // start sampled at the edge ending cycle st_cyc; out_valid two edges later
      check("first_valid_latency", first_valid - (st_cyc + 1), 2);
      check("done_after_last_beat", done_cyc - last_beat_cyc, 1);
    end
    exp_addr.delete();
    exp_data.delete();
  endtask

  initial begin
    int b0, d0;
    bit hit;
    rst = 1'b1;
    rf_wr_en = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.length = '0;
    bus.out_ready = 1'b1;

    fork
      forever begin
        @(posedge clk); #1;
        if (ready_mode == 0) begin
          bus.out_ready = 1'b1;
        end else begin
          bus.out_ready = ready_pat[ready_ph];
          ready_ph = (ready_ph + 1) % 6;
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_rd_en", int'(bus.rf_rd_me_en), 0);
    check("rst_rd_addr", int'(bus.rf_rd_addr), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    rst = 1'b0;

    for (int i = 0; i < RfWords; i++) begin
      rf_wr_en = 1'b1;
      rf_wr_addr = AW'(i);
      rf_wr_data = DW'(i);
      @(posedge clk); #1;
    end
    rf_wr_en = 1'b0;

    ready_mode = 0;
    run_burst(10'h010, 4, 1'b0);
    run_burst(10'h3FE, 4, 1'b0);
    ready_mode = 1;
    run_burst(10'h040, 8, 1'b0);
    ready_mode = 0;
    run_burst(10'h123, 0, 1'b0);

    // Reset in the middle of a 10-word burst.
    push_expected(10'h020, 10);
    b0 = beat_total;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.base_addr = 10'h020;
    bus.length = 11'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (beat_total - b0 >= 3) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!hit) check("three_beats_timeout", 0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_addr.delete();
    exp_data.delete();
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_rd_addr", int'(bus.rf_rd_addr), 0);
    rst = 1'b0;
    d0 = done_total;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_done", done_total - d0, 0);
    check("midrst_idle_no_read", int'(bus.rf_rd_me_en), 0);
    run_burst(10'h000, 2, 1'b0);

    run_burst(10'h080, 5, 1'b1);
    run_burst(10'h155, RfWords, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
